// File: rtl/clock_supervisor_pkg.sv
// Shared types and helpers for the PLL/DCM lock supervisor.
// Holds the supervisor state encoding and the counter-width helper.
package clock_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  // Counter must be able to hold the largest of the three cycle counts.
  function automatic int cnt_width(input int rst_cycles,
                                   input int lock_timeout,
                                   input int stable_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single-bit level crossing into clk.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clock_lock_supervisor.sv
// Drives the clock controller reset, waits for a stable lock, qualifies
// clocks_ready and retries (optionally bounded) on timeout or lock loss.
module clock_lock_supervisor
  import clock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 0,
  parameter int CNT_W         = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES),
  parameter int RETRY_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_async,
  output logic               pll_rst,
  output logic               clocks_ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic               fail
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic locked_s;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked_async),
    .q   (locked_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               pll_rst_q, pll_rst_d;
  logic               clocks_ready_q, clocks_ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic               fail_q, fail_d;
  logic               retry_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    retry_req   = 1'b0;
    retry_inc   = (&retry_q) ? retry_q : retry_q + 1'b1;

    case (state_q)
      RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Lock seen on the timeout cycle takes priority over the retry.
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          retry_req = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          lock_lost_d = 1'b1;
          retry_req   = 1'b1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
      end
    endcase

    if (retry_req) begin
      retry_d = retry_inc;
      cnt_d   = '0;
      if (MAX_RETRIES != 0 && int'(retry_inc) >= MAX_RETRIES) state_d = FAIL;
      else                                                   state_d = RESET;
    end

    // Outputs are registered from the next state so they align with it.
    pll_rst_d      = (state_d == RESET) || (state_d == FAIL);
    clocks_ready_d = (state_d == RUN);
    fail_d         = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RESET;
      cnt_q          <= '0;
      retry_q        <= '0;
      pll_rst_q      <= 1'b1;
      clocks_ready_q <= 1'b0;
      lock_lost_q    <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      pll_rst_q      <= pll_rst_d;
      clocks_ready_q <= clocks_ready_d;
      lock_lost_q    <= lock_lost_d;
      fail_q         <= fail_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign clocks_ready = clocks_ready_q;
  assign lock_lost    = lock_lost_q;
  assign retry_count  = retry_q;
  assign fail         = fail_q;

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// Scoreboard bench: stimulus queues each expected output change with the
// clock edge it should appear on; a monitor pops on every observed change.
module tb_clock_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       locked_async;
  logic       pll_rst;
  logic       clocks_ready;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic       fail;

  clock_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .CNT_W         (8),
    .RETRY_W       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked_async (locked_async),
    .pll_rst      (pll_rst),
    .clocks_ready (clocks_ready),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .fail         (fail)
  );

  typedef struct {
    int          cyc;
    logic [11:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tuple order: {pll_rst, clocks_ready, lock_lost, fail, retry_count}
  task automatic push(input int c, input logic p, input logic r,
                      input logic l, input logic f, input logic [7:0] rc);
    exp_t e;
    e.cyc = c;
    e.val = {p, r, l, f, rc};
    exp_q.push_back(e);
  endtask

  // Stimulus: each push names the absolute edge of an expected output change.
  initial begin
    rst = 1'b1;
    locked_async = 1'b0;
    step(3);
    push(3, 1, 0, 0, 0, 8'd0);          // reset state
    push(7, 0, 0, 0, 0, 8'd0);          // pll_rst high for 4 cycles
    mon_en = 1'b1;
    rst = 1'b0;

    // Lock 10 cycles after pll_rst falls; ready 11 edges later.
    step(14);
    locked_async = 1'b1;
    push(28, 0, 1, 0, 0, 8'd0);

    // One-cycle lock drop in RUN.
    step(15);
    locked_async = 1'b0;
    push(35, 1, 0, 1, 0, 8'd1);
    push(36, 1, 0, 0, 0, 8'd1);
    push(39, 0, 0, 0, 0, 8'd1);
    push(48, 0, 1, 0, 0, 8'd1);
    step(1);
    locked_async = 1'b1;

    // Reset, then drop lock while STABLE counter is at 5.
    step(19);
    rst = 1'b1;
    push(53, 1, 0, 0, 0, 8'd0);
    push(57, 0, 0, 0, 0, 8'd0);
    step(1);
    rst = 1'b0;
    step(8);
    locked_async = 1'b0;
    push(64, 1, 0, 0, 0, 8'd1);
    push(68, 0, 0, 0, 0, 8'd1);

    // locked_s rises exactly on the last WAIT_LOCK cycle: lock wins.
    step(24);
    locked_async = 1'b1;
    push(96, 0, 1, 0, 0, 8'd1);

    // Never lock: three timeouts then FAIL.
    step(15);
    locked_async = 1'b0;
    rst = 1'b1;
    push(101, 1, 0, 0, 0, 8'd0);
    push(105, 0, 0, 0, 0, 8'd0);
    push(125, 1, 0, 0, 0, 8'd1);
    push(129, 0, 0, 0, 0, 8'd1);
    push(149, 1, 0, 0, 0, 8'd2);
    push(153, 0, 0, 0, 0, 8'd2);
    push(173, 1, 0, 0, 1, 8'd3);
    step(1);
    rst = 1'b0;

    // FAIL ignores a returning lock; only rst leaves it.
    step(74);
    locked_async = 1'b1;
    step(15);
    rst = 1'b1;
    push(191, 1, 0, 0, 0, 8'd0);
    push(195, 0, 0, 0, 0, 8'd0);
    step(1);
    rst = 1'b0;

    // One-cycle rst while in STABLE.
    step(7);
    rst = 1'b1;
    push(199, 1, 0, 0, 0, 8'd0);
    push(203, 0, 0, 0, 0, 8'd0);
    push(212, 0, 1, 0, 0, 8'd0);
    step(1);
    rst = 1'b0;

    step(16);
    done = 1'b1;
  end

  // Monitor: every change of the output tuple must match the queue head.
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    exp_t        e;
    prev = 'x;
    while (!done) begin
      @(negedge clk);
      if (mon_en && !done) begin
        cur = {pll_rst, clocks_ready, lock_lost, fail, retry_count};
        if (cur !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%h required=no_change", cyc, cur);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.val !== cur) begin
              errors++;
              $display("FAIL out_change got cyc=%0d val=%h required cyc=%0d val=%h",
                       cyc, cur, e.cyc, e.val);
            end
          end
          prev = cur;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_changes got=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_lock_supervisor.md
Name: clock_lock_supervisor

Overview:
Supervises the clock controller's PLL/DCM chain from the free-running 33 MHz board clock. It drives the chain's reset input and monitors its asynchronous `locked` output. Lock timeouts and lock loss trigger bounded retries. `clocks_ready` is qualified only after lock has been stable for a programmed time. It sits directly upstream of the clock controller (feeds its `rst`) and consumes that controller's `locked`.

Parameters:
RST_CYCLES, 16, cycles `pll_rst` is held high per reset attempt (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before retry (~2 ms at 33 MHz; >=1)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before ready (>=1)
MAX_RETRIES, 0, retries before entering FAIL; 0 = retry forever
CNT_W, 17, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)
RETRY_W, 8, width of `retry_count`

Ports:
clk  in  1  free-running 33 MHz reference clock; the only clock
rst  in  1  synchronous, active-high reset
locked_async  in  1  lock status from clock controller, asynchronous to clk
pll_rst  out  1  reset to clock controller, active high
clocks_ready  out  1  high while derived clocks are qualified stable
lock_lost  out  1  one-cycle pulse when lock drops while in RUN
retry_count  out  RETRY_W  number of retries since rst, saturating
fail  out  1  high in FAIL state

Behaviour:
- Reset and clocking: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Synchronizer: 2-flop synchronizer on `locked_async`, reset to 0, output `locked_s`. All decisions use `locked_s` only.
- Values while `rst` is high and on the first cycle after it: state=RESET, cnt=0, `pll_rst`=1, `clocks_ready`=0, `lock_lost`=0, `retry_count`=0, `fail`=0.
- All outputs are registered. `pll_rst`=1 in RESET and FAIL. `clocks_ready`=1 only in RUN.
- RESET:
  - cnt increments each cycle.
  - When cnt==RST_CYCLES-1: go to WAIT_LOCK with cnt=0.
  - `pll_rst` is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If `locked_s`=1: go to STABLE with cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: retry (see below).
  - Else cnt++.
  - If `locked_s` rises on the timeout cycle, lock wins: go to STABLE, no retry.
- STABLE:
  - If `locked_s`=0: retry.
  - Else if cnt==STABLE_CYCLES-1: go to RUN.
  - Else cnt++.
  - Resulting latency: `clocks_ready` rises STABLE_CYCLES+1 cycles after the WAIT_LOCK cycle that first sampled `locked_s`=1.
- RUN:
  - Hold while `locked_s`=1.
  - On `locked_s`=0: pulse `lock_lost` for one cycle, clear `clocks_ready` on the same edge, then retry.
- Retry:
  - Increment `retry_count` (saturates at all-ones).
  - If MAX_RETRIES!=0 and the incremented count >= MAX_RETRIES: go to FAIL.
  - Otherwise go to RESET with cnt=0.
- FAIL:
  - `pll_rst`=1 and `fail`=1.
  - Absorbing state; exits only via `rst`.
- Glitches: a `locked_async` glitch shorter than one clk period may or may not be captured. If captured, it is treated as a real transition.
- `rst` asserted mid-operation from any state returns to RESET on the next edge. `retry_count` is cleared.

Decomposition:
- Package `clock_supervisor_pkg`:
  - state enum {RESET, WAIT_LOCK, STABLE, RUN, FAIL}
  - function to compute CNT_W from the three cycle parameters.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset value parameter, reusable across the design.
- One shared counter `cnt`, reused per state.

Test Plan:
(Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.)
1. Release rst, raise `locked_async` 10 cycles after `pll_rst` falls -> `pll_rst` high 4 cycles; `clocks_ready` rises 2 (sync) + 9 cycles after the `locked_async` edge; `retry_count`=0.
2. Never raise locked -> `pll_rst` pulses of 4 cycles separated by 20 low cycles; `retry_count` goes 1,2,3; then `fail`=1 with `pll_rst` held high. `rst` clears all of it.
3. In RUN, drop locked for 1 cycle -> `lock_lost` single pulse; `clocks_ready` low; `retry_count`=1; new 4-cycle `pll_rst`; re-lock gives ready again.
4. In STABLE, drop locked at cnt=5 -> no ready; retry to RESET; `retry_count`=1; no `lock_lost` pulse.
5. `locked_s` rises exactly on cycle cnt=19 of WAIT_LOCK -> STABLE entered, `retry_count` unchanged.
6. Assert `rst` for 1 cycle during STABLE and during FAIL -> next cycle: state RESET, `pll_rst`=1, all other outputs 0.
